// File: rtl/afifo_rd_unpacker.sv
// afifo_rd_unpacker: pops wide words from a first-word-fall-through async FIFO
// read port and streams each word out as C_RATIO narrow beats, LSB beat first.
module afifo_rd_unpacker #(
  parameter int unsigned C_IN_WIDTH  = 32,
  parameter int unsigned C_RATIO     = 4,
  localparam int unsigned C_OUT_WIDTH = C_IN_WIDTH / C_RATIO,
  localparam int unsigned CNT_WIDTH   = (C_RATIO > 1) ? $clog2(C_RATIO) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fifo_empty,
  input  logic [C_IN_WIDTH-1:0]  i_fifo_data,
  output logic                   o_fifo_ren,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [C_OUT_WIDTH-1:0] o_data,
  output logic                   o_last,
  output logic                   o_busy
);

  // IDLE holds nothing; SHIFT holds a word and presents one of its beats.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [C_IN_WIDTH-1:0]   word_q,  word_d;
  logic [CNT_WIDTH-1:0]    cnt_q,   cnt_d;
  logic                    valid_q;
  logic                    accept;
  logic                    last;
  logic                    load;

  assign valid_q = (state_q == ST_SHIFT);

  // State, held word and beat index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance the beat index on accept, refill on the last beat
  // (back-to-back) or drop to IDLE when the FIFO has nothing to give.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    last    = (cnt_q == CNT_WIDTH'(C_RATIO - 1));
    accept  = valid_q & i_ready;
    load    = !i_rst & !i_fifo_empty & (!valid_q | (accept & last));

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          word_d  = i_fifo_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          if (!last) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else if (load) begin
            word_d = i_fifo_data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Beat select: beat 0 is the least significant slice of the word.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < int'(C_RATIO); i++) begin
      if (cnt_q == CNT_WIDTH'(i)) begin
        o_data = word_q[i*C_OUT_WIDTH +: C_OUT_WIDTH];
      end
    end
  end

  // The pop is combinational so the FIFO head can be taken in the same
  // cycle the last beat of the previous word is accepted.
  assign o_fifo_ren = load;
  assign o_valid    = valid_q;
  assign o_busy     = valid_q;
  assign o_last     = last;

endmodule

// File: doc/afifo_rd_unpacker.md
# afifo_rd_unpacker

Read-side consumer for the asynchronous FIFO: pops wide words from the FIFO's first-word-fall-through read port in the read clock domain and emits them as a sequence of narrower beats on a valid/ready stream. It sits directly downstream of the FIFO's read interface (`i_ren`, `o_empty`, `o_rd_data`) and feeds the width-narrow compute pipeline. It sustains one beat per cycle with no bubble between words.

## Interface
- `C_IN_WIDTH`, default 32: FIFO word width; must be an integer multiple of `C_RATIO`.
- `C_RATIO`, default 4: beats per FIFO word; must be ≥1.
- `C_OUT_WIDTH` (localparam): `C_IN_WIDTH / C_RATIO`.
- `CNT_WIDTH` (localparam): `$clog2(C_RATIO)`, or 1 when `C_RATIO == 1`.

Ports:
- `i_clk`  in  1  read-domain clock, the same clock as the FIFO's `i_rclk`.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `i_fifo_data`  in  `C_IN_WIDTH`  FIFO head word; valid whenever `i_fifo_empty` is 0.
- `o_fifo_ren`  out  1  pop request; the FIFO advances at the next `i_clk` edge.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts the beat.
- `o_data`  out  `C_OUT_WIDTH`  current beat.
- `o_last`  out  1  current beat is the final beat of its word.
- `o_busy`  out  1  a word is held; equals `o_valid`.

## Operation
- **Registers**
  - `word_q [C_IN_WIDTH]`: holds the current word.
  - `cnt_q [CNT_WIDTH]`: index of the current beat.
  - `valid_q`: output-valid flag.
- **States**, encoded by `valid_q`:
  - IDLE (`valid_q = 0`)
  - SHIFT (`valid_q = 1`)
- **Derived signals**
  - `accept = o_valid & i_ready`
  - `o_last = (cnt_q == C_RATIO-1)`
  - `o_data = word_q[cnt_q*C_OUT_WIDTH +: C_OUT_WIDTH]`, beat 0 = LSBs.
- **Load condition:** `load = !i_rst & !i_fifo_empty & (!valid_q | (accept & o_last))`.
- **Pop:** `o_fifo_ren = load`, combinational. It is never asserted while `i_fifo_empty = 1` or while `i_rst = 1`.
- **Transitions**
  - IDLE → SHIFT on `load`: `word_q <= i_fifo_data`, `cnt_q <= 0`, `valid_q <= 1`.
  - SHIFT, `accept & !o_last`: `cnt_q <= cnt_q + 1`; `word_q` unchanged.
  - SHIFT, `accept & o_last & load`: new word loaded, `cnt_q <= 0`, stays SHIFT. This is the back-to-back case.
  - SHIFT, `accept & o_last & !load`: `valid_q <= 0` → IDLE; `cnt_q <= 0`.
  - SHIFT, `!accept`: hold all registers.
- **Stream rule:** while `o_valid = 1` and `i_ready = 0`, `o_data` and `o_last` are stable.
- **`C_RATIO == 1`:** `cnt_q` stays 0, `o_last` is constantly 1, and the block acts as a one-deep registered stage.
- **Wrap:** `cnt_q` never exceeds `C_RATIO-1`. For non-power-of-two ratios it returns to 0 through a load or IDLE, never by natural overflow.

## Timing
- **Reset** (held ≥1 cycle), at the first edge with `i_rst = 1`:
  - `valid_q = 0`, `cnt_q = 0`, `word_q = 0`.
  - Outputs: `o_valid = 0`, `o_busy = 0`, `o_data = 0`.
  - `o_last = 0` unless `C_RATIO == 1`.
  - `o_fifo_ren = 0` throughout reset.
- **Reset mid-word:** the remaining beats of the held word are discarded. The FIFO entry was already popped and is lost.
- **Latency:** the FIFO non-empty in cycle N (block IDLE) gives `o_fifo_ren = 1` in cycle N and `o_valid = 1` with beat 0 in cycle N+1.
- **Throughput:** 1 beat/cycle with `i_ready` held high. A word occupies exactly `C_RATIO` cycles, with no gap between words while the FIFO stays non-empty.
- **Empty while a last beat is accepted:** `o_valid` drops the next cycle. `o_fifo_ren` rises in the same cycle that `i_fifo_empty` falls.
- **Backpressure:** no pop occurs while the last beat is stalled. The FIFO sees backpressure only through missing pops.

## Test plan
- **Reset:** assert `i_rst` for 3 cycles with `i_fifo_empty = 0` → `o_fifo_ren = 0` and `o_valid = 0` throughout; after release, beat 0 appears 1 cycle later.
- **Single word** (`C_RATIO = 4`): word `0xDDCCBBAA`, `i_ready = 1` → beats `0xAA`, `0xBB`, `0xCC`, `0xDD` on 4 consecutive cycles, `o_last` only on `0xDD`, then `o_valid = 0`.
- **Back-to-back:** 3 words queued, `i_ready = 1` → 12 beats on consecutive cycles, `o_fifo_ren` pulses exactly on cycles 0, 4 and 8 relative to the first pop, no bubble.
- **Backpressure:** `i_ready` is random (50%) for 64 words → the output sequence is identical to the reference unpacking, `o_data`/`o_last` stable during stalls, and no pop while `o_last` is stalled.
- **Reset mid-word:** pulse `i_rst` after beat 1 of a word → `o_valid` is 0 the next cycle and the stream resumes at beat 0 of the following FIFO word.
- **`C_RATIO = 1`:** words 1..16 with `i_ready` toggling → each word is emitted once, `o_last` is always 1, and throughput reaches 1 word/cycle when `i_ready = 1`.
